seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Multi-digit, time-multiplexed seven-segment display driver: the parametrised successor to the single-digit hex decoder. Accepts an NDIG-digit hex value, double-buffers it so updates never tear mid-frame, and scans one digit at a time with a programmable dwell, a per-slot anti-ghosting blank cycle, per-digit enable, decimal points and optional leading-zero suppression. Sits between the board-level display pins and any core/peripheral that wants to show a number.

## Interface

Parameters:
- NDIG, 8, number of digits (2..16)
- CLK_DIV, 1000, clock cycles per digit slot (>= 2)
- ACTIVE_LOW, 1, 1: seg/dp/an driven active-low (common-anode); 0: active-high

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- value  in  4*NDIG  hex digits, digit i = value[4i+3:4i], digit 0 least significant
- load  in  1  capture value into pending buffer this cycle
- dp_in  in  NDIG  decimal point request per digit
- en_mask  in  NDIG  per-digit enable; 0 = digit always blanked
- lz_blank  in  1  leading-zero suppression enable
- seg  out  7  segments, bit0=a .. bit6=g
- dp  out  1  decimal point segment
- an  out  NDIG  digit select, one-hot when active
- scan_idx  out  $clog2(NDIG)  digit index currently driven
- frame_done  out  1  one-cycle pulse at start of each new frame

## Operation

- Counters: div_cnt 0..CLK_DIV-1, increments every cycle, wraps to 0; on wrap idx increments, wrapping NDIG-1 -> 0. "Frame wrap" = cycle with div_cnt==CLK_DIV-1 and idx==NDIG-1.
- Buffering: load writes value into pending and sets pending_valid. Multiple loads in a frame: last wins. On frame wrap: if load is high that cycle, disp <= value (bypass); else if pending_valid, disp <= pending; pending_valid clears in either case. disp never changes at any other time.
- Font (logical, before polarity), digit 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- Leading-zero suppression (lz_blank=1): starting from digit NDIG-1 downward, every digit whose disp nibble is 0 and all higher digits are 0 is blanked; digit 0 is never suppressed. lz_blank=0: no suppression.
- Digit is blanked if en_mask[idx]==0 or suppressed. Blanked slot: an all inactive, seg all off, dp off.
- Guard: whenever div_cnt==0, an all inactive, seg off, dp off (anti-ghosting).
- Otherwise: an = one-hot at idx, seg = font(disp nibble idx), dp = dp_in[idx]; all polarity-inverted when ACTIVE_LOW=1.
- dp_in, en_mask, lz_blank are sampled live (not buffered).

## Timing

- All outputs registered: seg/dp/an/scan_idx reflect counter state of the previous cycle (1-cycle lag).
- frame_done high exactly the cycle after frame wrap (i.e. when output scan_idx first shows 0 of a new frame); period NDIG*CLK_DIV cycles.
- Each digit: 1 guard cycle + CLK_DIV-1 lit cycles.
- load-to-visible latency: at most one full frame plus 1 cycle; load on frame-wrap cycle visible in the immediately following frame.
- Reset (any time, including mid-frame or mid-load): div_cnt=0, idx=0, disp=0, pending=0, pending_valid=0; next cycle outputs: an all inactive, seg off, dp off (inactive level per ACTIVE_LOW), scan_idx=0, frame_done=0. First frame after reset displays 0 on all enabled, non-suppressed digits.

## Test plan

- NDIG=4, CLK_DIV=4, ACTIVE_LOW=1, en_mask=4'hF, reset then idle -> an sequence per slot: 1111 (guard), then 1110 x3, 1111, 1101 x3, ... 0111 x3; seg=7'b1000000 in lit cycles; frame_done pulses every 16 cycles.
- load 16'h12AF mid-frame -> current frame still shows 0000; after next frame_done digits 3..0 show seg 7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110.
- lz_blank=1, disp=16'h0050 -> slots 3,2 an=1111 whole slot, digit1 seg=7'b0010010, digit0 seg=7'b1000000; disp=16'h0000 -> only digit0 lit with "0".
- load 16'h1111 then 16'h2222 in same frame -> next frame shows 2222; load 16'h3333 exactly on frame-wrap cycle -> next frame shows 3333.
- en_mask=4'b1011, dp_in=4'b0001 -> digit2 slot an=1111 throughout; dp=0 only during digit0 lit cycles, 1 elsewhere.
- assert rst for one cycle at idx=2, div_cnt=2 with pending_valid=1 -> next cycle all outputs inactive, scan_idx=0; pending discarded, following frame shows 0000.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed NDIG-digit seven-segment driver with frame-synchronous double
// buffering, a blank guard cycle per slot, per-digit enable, decimal points and zero blanking.
module seg7_scan_driver #(
  parameter int unsigned NDIG       = 8,
  parameter int unsigned CLK_DIV    = 1000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NDIG-1:0]         value,
  input  logic                      load,
  input  logic [NDIG-1:0]           dp_in,
  input  logic [NDIG-1:0]           en_mask,
  input  logic                      lz_blank,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NDIG-1:0]           an,
  output logic [$clog2(NDIG)-1:0]   scan_idx,
  output logic                      frame_done
);

  localparam int unsigned IW = $clog2(NDIG);
  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DivMax = DW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IdxMax = IW'(NDIG - 1);

  logic [DW-1:0]     div_q, div_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] disp_q, disp_d;
  logic [4*NDIG-1:0] pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              wrap_q, wrap_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [IW-1:0]     scan_idx_q, scan_idx_d;
  logic              frame_done_q, frame_done_d;

  logic              div_wrap;
  logic              frame_wrap;
  logic [NDIG-1:0]   sup;
  logic              zero_above;
  logic [3:0]        nib;
  logic              lit;
  logic [6:0]        seg_l;
  logic              dp_l;
  logic [NDIG-1:0]   an_l;

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0:    font = 7'h3F;
      4'h1:    font = 7'h06;
      4'h2:    font = 7'h5B;
      4'h3:    font = 7'h4F;
      4'h4:    font = 7'h66;
      4'h5:    font = 7'h6D;
      4'h6:    font = 7'h7D;
      4'h7:    font = 7'h07;
      4'h8:    font = 7'h7F;
      4'h9:    font = 7'h6F;
      4'hA:    font = 7'h77;
      4'hB:    font = 7'h7C;
      4'hC:    font = 7'h39;
      4'hD:    font = 7'h5E;
      4'hE:    font = 7'h79;
      default: font = 7'h71;
    endcase
  endfunction

  always_comb begin
    div_wrap   = (div_q == DivMax);
    frame_wrap = div_wrap && (idx_q == IdxMax);
    div_d      = div_wrap ? '0 : div_q + 1'b1;
    idx_d      = idx_q;
    if (div_wrap) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
    wrap_d = frame_wrap;
  end

  // The displayed buffer only ever changes on the frame boundary so a frame never tears.
  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    disp_d     = disp_q;
    if (load) begin
      pend_d     = value;
      pend_vld_d = 1'b1;
    end
    if (frame_wrap) begin
      if (load) begin
        disp_d = value;
      end else if (pend_vld_q) begin
        disp_d = pend_q;
      end
      pend_vld_d = 1'b0;
    end
  end

  // zero_above: this digit and every higher one are zero; digit 0 is always shown.
  always_comb begin
    sup        = '0;
    zero_above = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      if (disp_q[4*i +: 4] != 4'h0) begin
        zero_above = 1'b0;
      end
      sup[i] = lz_blank && zero_above;
    end
  end

  always_comb begin
    nib   = disp_q[{idx_q, 2'b00} +: 4];
    lit   = (div_q != '0) && en_mask[idx_q] && !sup[idx_q];
    seg_l = lit ? font(nib) : 7'h00;
    dp_l  = lit && dp_in[idx_q];
    an_l  = '0;
    if (lit) begin
      an_l[idx_q] = 1'b1;
    end
    seg_d        = seg_l ^ {7{ACTIVE_LOW}};
    dp_d         = dp_l ^ ACTIVE_LOW;
    an_d         = an_l ^ {NDIG{ACTIVE_LOW}};
    scan_idx_d   = idx_q;
    frame_done_d = wrap_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      wrap_q       <= 1'b0;
      seg_q        <= {7{ACTIVE_LOW}};
      dp_q         <= ACTIVE_LOW;
      an_q         <= {NDIG{ACTIVE_LOW}};
      scan_idx_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      wrap_q       <= wrap_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      scan_idx_q   <= scan_idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign scan_idx   = scan_idx_q;
  assign frame_done = frame_done_q;

endmodule
